// File: rtl/shift_arb_pkg.sv
// Shared definitions for the barrel shift arbiter.
//   DATA_W / SHAMT_W : operand width and shift-amount width
//   MAX_REQ          : largest supported requester count
//   arb_state_e      : arbiter FSM encoding
//   rr_pick()        : round-robin pick (valid vector, pointer -> index)
package shift_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // First valid index at or above ptr, wrapping modulo num_req.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int ptr,
                                   input int num_req);
        int   idx;
        int   pick;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % num_req;
            if ((i < num_req) && !found && valid[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shift_right_core.sv
// Registered logical right barrel shifter, one log2 stage per amount bit.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the output register
//   data_i : operand
//   amt_i  : shift amount
//   data_o : data_i >> amt_i, one cycle later (zero fill from the MSB)
module shift_right_core
    import shift_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] w_stage [SHAMT_W+1];
    logic [DATA_W-1:0] r_data;

    assign w_stage[0] = data_i;

    // Stage s shifts by 2**s when amount bit s is set.
    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        assign w_stage[s+1] = amt_i[s] ? (w_stage[s] >> (2 ** s)) : w_stage[s];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
        end else begin
            r_data <= w_stage[SHAMT_W];
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin scheduler sharing one registered right barrel shifter among
// NUM_REQ requesters. Flow: IDLE (grant + latch) -> SHIFT -> RESP (hold
// until consumer ready) -> IDLE.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the requester holds valid/data/amount stable until ready, and
// the response side holds rsp_valid_o/data/id stable until rsp_ready_i.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_valid_i   : per-requester valid
//   req_data_i    : flat operands, requester k at [k*DATA_W +: DATA_W]
//   req_amt_i     : flat amounts, requester k at [k*SHAMT_W +: SHAMT_W]
//   req_ready_o   : one-hot accept strobe (IDLE only)
//   rsp_valid_o, rsp_data_o, rsp_id_o, rsp_ready_i : response channel
//   busy_o        : high when not IDLE
//   dbg_state_o   : current FSM state
//   grant_cnt_o   : per-requester 16-bit saturating grant counters, present
//                   only when SHIFT_ARB_STATS_EN is defined
module barrel_shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_amt_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic [ID_W-1:0]            rsp_id_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o,
    output arb_state_e                 dbg_state_o
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      grant_cnt_o
`endif
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [DATA_W-1:0]  r_opnd;
    logic [SHAMT_W-1:0] r_amt;
    logic [ID_W-1:0]    w_grant;
    logic               w_accept;
    logic [DATA_W-1:0]  w_shift_q;

    assign w_grant  = ID_W'(rr_pick(MAX_REQ'(req_valid_i), int'(r_rr_ptr), NUM_REQ));
    assign w_accept = (r_state == IDLE) && (|req_valid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (w_accept) begin
                    req_ready_o[w_grant] = 1'b1;
                    w_state_nxt          = SHIFT;
                end
            end
            SHIFT: w_state_nxt = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands are only loaded on accept, so the free-running shifter keeps
    // re-registering the same result and rsp_data_o is stable in RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_opnd   <= '0;
            r_amt    <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant == LAST_ID) ? '0 : w_grant + 1'b1;
            r_id     <= w_grant;
            r_opnd   <= req_data_i[w_grant*DATA_W +: DATA_W];
            r_amt    <= req_amt_i[w_grant*SHAMT_W +: SHAMT_W];
        end
    end

    shift_right_core u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i (r_opnd),
        .amt_i  (r_amt),
        .data_o (w_shift_q)
    );

    assign rsp_data_o  = w_shift_q;
    assign rsp_id_o    = r_id;
    assign dbg_state_o = r_state;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_grant_cnt[k] <= '0;
            end else if (w_accept && (w_grant == ID_W'(k)) && (r_grant_cnt[k] != 16'hFFFF)) begin
                r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
            end
        end
        assign grant_cnt_o[k*16 +: 16] = r_grant_cnt[k];
    end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter (NUM_REQ = 4).
module tb_barrel_shift_arbiter;
    import shift_arb_pkg::*;

    logic         clk_i;
    logic         rst_ni;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [19:0]  req_amt_i;
    logic [3:0]   req_ready_o;
    logic         rsp_valid_o;
    logic [31:0]  rsp_data_o;
    logic [1:0]   rsp_id_o;
    logic         rsp_ready_i;
    logic         busy_o;
    arb_state_e   dbg_state;
`ifdef SHIFT_ARB_STATS_EN
    logic [63:0]  grant_cnt_o;
`endif

    logic [31:0] tb_data [4];
    logic [4:0]  tb_amt  [4];
    logic [31:0] tb_exp  [4];
    logic [3:0]  hold_mask;

    logic [33:0] exp_q [$];
    int          grant_q [$];
    int          n_checks;
    int          n_errors;

    assign req_data_i = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
    assign req_amt_i  = {tb_amt[3], tb_amt[2], tb_amt[1], tb_amt[0]};

    barrel_shift_arbiter #(.NUM_REQ(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_amt_i   (req_amt_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] a,
                           input logic [31:0] e);
        tb_data[k] = d;
        tb_amt[k]  = a;
        tb_exp[k]  = e;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready_o), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
        check({tag, "_rsp_data"}, rsp_data_o, 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // One isolated request from k with exact cycle timing; rsp_ready_i = 1.
    task automatic single_txn(input int k, input logic [31:0] d, input logic [4:0] a,
                              input logic [31:0] e);
        @(posedge clk_i); #2;
        set_req(k, d, a, e);
        req_valid_i[k] = 1'b1;
        @(negedge clk_i);
        check("single_ready", 32'(req_ready_o), 32'(1) << k);
        check("single_busy_idle", 32'(busy_o), 32'h0);
        @(posedge clk_i); #2;
        req_valid_i[k] = 1'b0;
        @(negedge clk_i);
        check("single_shift_valid", 32'(rsp_valid_o), 32'h0);
        check("single_shift_ready", 32'(req_ready_o), 32'h0);
        check("single_shift_busy", 32'(busy_o), 32'h1);
        @(negedge clk_i);
        check("single_rsp_valid", 32'(rsp_valid_o), 32'h1);
        check("single_rsp_data", rsp_data_o, e);
        check("single_rsp_id", 32'(rsp_id_o), 32'(k));
        @(posedge clk_i); #2;
        @(negedge clk_i);
        check("single_done_busy", 32'(busy_o), 32'h0);
        check("single_done_valid", 32'(rsp_valid_o), 32'h0);
    endtask

    // Driver + scoreboard loop: records grants, drops valid of granted
    // requesters not in hold_mask, and matches responses against exp_q.
    task automatic run_cycles(input int n);
        int g;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (req_ready_o[k]) g = k;
            end
            if (g >= 0) begin
                grant_q.push_back(g);
                exp_q.push_back({2'(g), tb_exp[g]});
            end
            if (rsp_valid_o && rsp_ready_i) begin
                check("sb_pending", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    logic [33:0] x;
                    x = exp_q.pop_front();
                    check("sb_rsp_id", 32'(rsp_id_o), 32'(x[33:32]));
                    check("sb_rsp_data", rsp_data_o, x[31:0]);
                end
            end
            @(posedge clk_i); #2;
            if (g >= 0 && !hold_mask[g]) req_valid_i[g] = 1'b0;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        hold_mask   = '0;
        for (int k = 0; k < 4; k++) set_req(k, 32'h0, 5'd0, 32'h0);
        rst_ni = 1'b0;
        #23;
        check_reset_outputs("reset");
        rst_ni = 1'b1;

        // All four valid right after reset: grants 0,1,2,3
        @(posedge clk_i); #2;
        set_req(0, 32'hFFFF0000, 5'd8,  32'h00FFFF00);
        set_req(1, 32'h12345678, 5'd4,  32'h01234567);
        set_req(2, 32'hDEADBEEF, 5'd16, 32'h0000DEAD);
        set_req(3, 32'h80000001, 5'd31, 32'h00000001);
        req_valid_i = 4'b1111;
        run_cycles(14);
        check("all4_grant_cnt", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_q.size()) check("all4_grant_order", 32'(grant_q[i]), 32'(i));
        end
        check("all4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fairness: req0 and req2 held valid -> 0,2,0,2
        grant_q.delete();
        set_req(0, 32'h0000F000, 5'd12, 32'h0000000F);
        set_req(2, 32'hC0000000, 5'd30, 32'h00000003);
        hold_mask   = 4'b0101;
        req_valid_i = 4'b0101;
        run_cycles(12);
        req_valid_i = '0;
        hold_mask   = '0;
        check("fair_grant_cnt", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_q.size()) check("fair_grant_seq", 32'(grant_q[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        check("fair_sb_empty", 32'(exp_q.size()), 32'd0);

        // Single request and shift-amount boundaries
        single_txn(0, 32'hF0F0F0F0, 5'd4,  32'h0F0F0F0F);
        single_txn(1, 32'h80000000, 5'd31, 32'h00000001);
        single_txn(2, 32'hF0F0F0F0, 5'd0,  32'hF0F0F0F0);
        single_txn(3, 32'hF0F0F0F0, 5'd1,  32'h78787878);

        // Backpressure: 5 RESP cycles with rsp_ready_i low, req2 waiting
        @(posedge clk_i); #2;
        rsp_ready_i = 1'b0;
        set_req(1, 32'h0000FFFF, 5'd8,  32'h000000FF);
        set_req(2, 32'hAAAA5555, 5'd12, 32'h000AAAA5);
        req_valid_i = 4'b0010;
        @(negedge clk_i);
        check("bp_grant", 32'(req_ready_o), 32'h2);
        @(posedge clk_i); #2;
        req_valid_i = 4'b0100;
        @(negedge clk_i);
        check("bp_shift_ready", 32'(req_ready_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_hold_valid", 32'(rsp_valid_o), 32'h1);
            check("bp_hold_data", rsp_data_o, 32'h000000FF);
            check("bp_hold_id", 32'(rsp_id_o), 32'h1);
            check("bp_hold_ready", 32'(req_ready_o), 32'h0);
        end
        @(posedge clk_i); #2;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_valid", 32'(rsp_valid_o), 32'h1);
        check("bp_release_data", rsp_data_o, 32'h000000FF);
        @(posedge clk_i); #2;
        @(negedge clk_i);
        check("bp_next_grant", 32'(req_ready_o), 32'h4);
        @(posedge clk_i); #2;
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("bp_next_data", rsp_data_o, 32'h000AAAA5);
        check("bp_next_id", 32'(rsp_id_o), 32'h2);
        @(posedge clk_i); #2;

        // Reset in SHIFT with req1 in flight
        set_req(1, 32'h12340000, 5'd16, 32'h00001234);
        req_valid_i = 4'b0010;
        @(negedge clk_i);
        check("rst_pre_grant", 32'(req_ready_o), 32'h2);
        @(posedge clk_i); #2;
        req_valid_i = '0;
        check("rst_in_shift", 32'(dbg_state), 32'(SHIFT));
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_no_rsp", 32'(rsp_valid_o), 32'h0);
        end
        @(posedge clk_i); #2;
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        check("rst_next_grant", 32'(req_ready_o), 32'h1);
        @(posedge clk_i); #2;
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_next_id", 32'(rsp_id_o), 32'h0);
        @(posedge clk_i); #2;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
